// File: rtl/guess_entry.sv
// Guess-entry stage of the Mastermind feedback comparator: builds a four-slot
// colour guess from button pulses, commits it to history and runs the game FSM.
module guess_entry #(
  parameter int NUM_COLORS = 6,
  parameter int MAX_TURNS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_submit,
  input  logic       new_game,
  input  logic [1:0] fb_ssd4,
  output logic [1:0] cur_slot,
  output logic [2:0] edit1,
  output logic [2:0] edit2,
  output logic [2:0] edit3,
  output logic [2:0] edit4,
  output logic [2:0] history1,
  output logic [2:0] history2,
  output logic [2:0] history3,
  output logic [2:0] history4,
  output logic [3:0] turn,
  output logic       guess_valid,
  output logic       new_code,
  output logic       playing,
  output logic       won,
  output logic       lost
);

  typedef enum logic [1:0] {
    S_EDIT  = 2'd0,
    S_CHECK = 2'd1,
    S_WON   = 2'd2,
    S_LOST  = 2'd3
  } state_t;

  localparam logic [2:0] LP_CMAX = 3'(NUM_COLORS - 1);
  localparam logic [3:0] LP_TMAX = 4'(MAX_TURNS);

  state_t     r_state,    w_state;
  logic [1:0] r_slot,     w_slot;
  logic [2:0] r_edit [4];
  logic [2:0] w_edit [4];
  logic [2:0] r_hist [4];
  logic [2:0] r_hist_n [4];
  logic [3:0] r_turn,     w_turn;
  logic       r_new_code, w_new_code;

  always_comb begin
    w_state    = r_state;
    w_slot     = r_slot;
    w_edit     = r_edit;
    r_hist_n   = r_hist;
    w_turn     = r_turn;
    w_new_code = 1'b0;

    if (new_game) begin
      w_state    = S_EDIT;
      w_slot     = '0;
      w_edit     = '{default: '0};
      r_hist_n   = '{default: '0};
      w_turn     = '0;
      w_new_code = 1'b1;
    end else begin
      case (r_state)
        S_EDIT: begin
          if (btn_submit) begin
            r_hist_n = r_edit;
            w_turn   = r_turn + 4'd1;
            w_state  = S_CHECK;
          end else begin
            // increment uses the pre-advance slot when up and next coincide
            if (btn_up)
              w_edit[r_slot] = (r_edit[r_slot] == LP_CMAX) ? 3'd0
                                                           : r_edit[r_slot] + 3'd1;
            if (btn_next)
              w_slot = r_slot + 2'd1;
          end
        end
        S_CHECK: begin
          if (fb_ssd4 == 2'd2)
            w_state = S_WON;
          else if (r_turn == LP_TMAX)
            w_state = S_LOST;
          else
            w_state = S_EDIT;
        end
        default: begin
          w_state = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EDIT;
      r_slot     <= '0;
      r_edit     <= '{default: '0};
      r_hist     <= '{default: '0};
      r_turn     <= '0;
      r_new_code <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_slot     <= w_slot;
      r_edit     <= w_edit;
      r_hist     <= r_hist_n;
      r_turn     <= w_turn;
      r_new_code <= w_new_code;
    end
  end

  assign cur_slot    = r_slot;
  assign edit1       = r_edit[0];
  assign edit2       = r_edit[1];
  assign edit3       = r_edit[2];
  assign edit4       = r_edit[3];
  assign history1    = r_hist[0];
  assign history2    = r_hist[1];
  assign history3    = r_hist[2];
  assign history4    = r_hist[3];
  assign turn        = r_turn;
  assign new_code    = r_new_code;
  assign guess_valid = (r_state == S_CHECK);
  assign playing     = (r_state == S_EDIT) || (r_state == S_CHECK);
  assign won         = (r_state == S_WON);
  assign lost        = (r_state == S_LOST);

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry: a vector table for editing/submit/win flow,
// plus hand sequences for wrap, new_game/rst in CHECK and turn-limit loss.
module tb_guess_entry;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, btn_next, btn_up, btn_submit, new_game;
  logic [1:0] fb_ssd4;

  logic [1:0] cur_slot, cur_slot_b;
  logic [2:0] e1, e2, e3, e4, h1, h2, h3, h4;
  logic [2:0] e1b, e2b, e3b, e4b, h1b, h2b, h3b, h4b;
  logic [3:0] turn, turn_b;
  logic gv, nc, pl, wn, ls;
  logic gv_b, nc_b, pl_b, wn_b, ls_b;

  guess_entry #(.NUM_COLORS(6), .MAX_TURNS(10)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_up(btn_up),
    .btn_submit(btn_submit), .new_game(new_game), .fb_ssd4(fb_ssd4),
    .cur_slot(cur_slot), .edit1(e1), .edit2(e2), .edit3(e3), .edit4(e4),
    .history1(h1), .history2(h2), .history3(h3), .history4(h4),
    .turn(turn), .guess_valid(gv), .new_code(nc), .playing(pl),
    .won(wn), .lost(ls)
  );

  guess_entry #(.NUM_COLORS(6), .MAX_TURNS(2)) dut_b (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_up(btn_up),
    .btn_submit(btn_submit), .new_game(new_game), .fb_ssd4(fb_ssd4),
    .cur_slot(cur_slot_b), .edit1(e1b), .edit2(e2b), .edit3(e3b), .edit4(e4b),
    .history1(h1b), .history2(h2b), .history3(h3b), .history4(h4b),
    .turn(turn_b), .guess_valid(gv_b), .new_code(nc_b), .playing(pl_b),
    .won(wn_b), .lost(ls_b)
  );

  // Packed views: colours as octal digits {slot1..slot4}, flags {gv,nc,playing,won,lost}
  logic [11:0] a_ed, a_hi;
  logic [4:0]  a_fl, b_fl;
  assign a_ed = {e1, e2, e3, e4};
  assign a_hi = {h1, h2, h3, h4};
  assign a_fl = {gv, nc, pl, wn, ls};
  assign b_fl = {gv_b, nc_b, pl_b, wn_b, ls_b};

  typedef struct {
    logic        rst, nx, up, sub, ng;
    logic [1:0]  fb;
    logic [1:0]  slot;
    logic [11:0] ed;
    logic [11:0] hi;
    logic [3:0]  turn;
    logic [4:0]  fl;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic nx, input logic up,
                      input logic sub, input logic ng, input logic [1:0] fb);
    @(negedge clk);
    rst = r; btn_next = nx; btn_up = up; btn_submit = sub; new_game = ng; fb_ssd4 = fb;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    rst = 1'b1; btn_next = 1'b0; btn_up = 1'b0; btn_submit = 1'b0;
    new_game = 1'b0; fb_ssd4 = 2'd0;

    //          rst nx up sb ng fb  slot  edit     history  turn flags
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 2'd0, 12'o0000, 12'o0000, 4'd0, 5'b01100};
    vecs[1]  = '{0, 0, 1, 0, 0, 0, 2'd0, 12'o1000, 12'o0000, 4'd0, 5'b00100};
    vecs[2]  = '{0, 0, 1, 0, 0, 0, 2'd0, 12'o2000, 12'o0000, 4'd0, 5'b00100};
    vecs[3]  = '{0, 0, 1, 0, 0, 0, 2'd0, 12'o3000, 12'o0000, 4'd0, 5'b00100};
    vecs[4]  = '{0, 1, 0, 0, 0, 0, 2'd1, 12'o3000, 12'o0000, 4'd0, 5'b00100};
    vecs[5]  = '{0, 0, 1, 0, 0, 0, 2'd1, 12'o3100, 12'o0000, 4'd0, 5'b00100};
    vecs[6]  = '{0, 1, 1, 0, 0, 0, 2'd2, 12'o3200, 12'o0000, 4'd0, 5'b00100};
    vecs[7]  = '{0, 1, 0, 0, 0, 0, 2'd3, 12'o3200, 12'o0000, 4'd0, 5'b00100};
    vecs[8]  = '{0, 1, 0, 0, 0, 0, 2'd0, 12'o3200, 12'o0000, 4'd0, 5'b00100};
    vecs[9]  = '{0, 0, 1, 1, 0, 1, 2'd0, 12'o3200, 12'o3200, 4'd1, 5'b10100};
    vecs[10] = '{0, 0, 1, 0, 0, 1, 2'd0, 12'o3200, 12'o3200, 4'd1, 5'b00100};
    vecs[11] = '{0, 0, 1, 0, 0, 0, 2'd0, 12'o4200, 12'o3200, 4'd1, 5'b00100};
    vecs[12] = '{0, 0, 0, 1, 0, 0, 2'd0, 12'o4200, 12'o4200, 4'd2, 5'b10100};
    vecs[13] = '{0, 0, 0, 0, 0, 2, 2'd0, 12'o4200, 12'o4200, 4'd2, 5'b00010};
    vecs[14] = '{0, 1, 1, 1, 0, 2, 2'd0, 12'o4200, 12'o4200, 4'd2, 5'b00010};
    vecs[15] = '{0, 0, 1, 0, 1, 0, 2'd0, 12'o0000, 12'o0000, 4'd0, 5'b01100};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 2'd0, 12'o0000, 12'o0000, 4'd0, 5'b00100};

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].nx, vecs[i].up, vecs[i].sub, vecs[i].ng, vecs[i].fb);
      chk($sformatf("v%0d slot", i),  32'(cur_slot), 32'(vecs[i].slot));
      chk($sformatf("v%0d edit", i),  32'(a_ed),     32'(vecs[i].ed));
      chk($sformatf("v%0d hist", i),  32'(a_hi),     32'(vecs[i].hi));
      chk($sformatf("v%0d turn", i),  32'(turn),     32'(vecs[i].turn));
      chk($sformatf("v%0d flags", i), 32'(a_fl),     32'(vecs[i].fl));
    end

    // Colour wrap on slot 0 (7 presses with 6 colours) and slot wrap
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("wrap edit1", 32'(e1), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("wrap slot", 32'(cur_slot), 32'd0);

    // Build {1,2,3,4}: slot0 already 1
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("build edit", 32'(a_ed), 32'(12'o1234));
    chk("build slot", 32'(cur_slot), 32'd0);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    chk("sub hist", 32'(a_hi), 32'(12'o1234));
    chk("sub turn", 32'(turn), 32'd1);
    chk("sub flags", 32'(a_fl), 32'(5'b10100));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    chk("post-check flags", 32'(a_fl), 32'(5'b00100));

    // new_game during CHECK
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("ng pre turn", 32'(turn), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    chk("ng turn", 32'(turn), 32'd0);
    chk("ng hist", 32'(a_hi), 32'd0);
    chk("ng flags", 32'(a_fl), 32'(5'b01100));

    // rst during CHECK beats a winning feedback
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("rst pre flags", 32'(a_fl), 32'(5'b10100));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    chk("rst turn", 32'(turn), 32'd0);
    chk("rst edit", 32'(a_ed), 32'd0);
    chk("rst flags", 32'(a_fl), 32'(5'b01100));

    // MAX_TURNS=2 instance: loss on turn limit
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("b1 flags", 32'(b_fl), 32'(5'b00100));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("b2 turn", 32'(turn_b), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("b lost flags", 32'(b_fl), 32'(5'b00001));
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    chk("b lost turn", 32'(turn_b), 32'd2);
    chk("b lost flags hold", 32'(b_fl), 32'(5'b00001));

    // Win on the final turn takes priority over loss
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    chk("b won flags", 32'(b_fl), 32'(5'b00010));
    chk("b won turn", 32'(turn_b), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
